// File: rtl/hardwired_control_seq_if.sv
// Control bundle between the hardwired sequencer (master) and the Datapath (slave).
// The sequencer reads Run and IR, and drives every Datapath control strobe.
interface hardwired_control_seq_if;
    logic        Run;
    logic [31:0] IR;

    logic PCout;
    logic Zhiout;
    logic Zlowout;
    logic MDRout;
    logic HIout;
    logic LOout;

    logic MARin;
    logic Zin;
    logic PCin;
    logic MDRin;
    logic IRin;
    logic Yin;
    logic HIin;
    logic LOin;

    logic IncPC;
    logic Read;

    logic Gra;
    logic Grb;
    logic Grc;
    logic Rin;
    logic Rout;

    logic ADD;
    logic SUB;
    logic AND;
    logic OR;
    logic MUL;
    logic DIV;

    logic       Done;
    logic       Illegal;
    logic [3:0] state;

    modport master (
        input  Run, IR,
        output PCout, Zhiout, Zlowout, MDRout, HIout, LOout,
        output MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin,
        output IncPC, Read,
        output Gra, Grb, Grc, Rin, Rout,
        output ADD, SUB, AND, OR, MUL, DIV,
        output Done, Illegal, state
    );

    modport slave (
        output Run, IR,
        input  PCout, Zhiout, Zlowout, MDRout, HIout, LOout,
        input  MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin,
        input  IncPC, Read,
        input  Gra, Grb, Grc, Rin, Rout,
        input  ADD, SUB, AND, OR, MUL, DIV,
        input  Done, Illegal, state
    );
endinterface

// File: rtl/hardwired_control_seq.sv
// Hardwired control sequencer: fetch (T0-T2) then a decode-driven execute sequence for
// 3-register ALU ops and 64-bit-result MUL/DIV. All strobes are decoded from state and IR.
module hardwired_control_seq #(
    parameter logic [4:0] OP_ADD = 5'b00000,
    parameter logic [4:0] OP_SUB = 5'b00001,
    parameter logic [4:0] OP_AND = 5'b00010,
    parameter logic [4:0] OP_MUL = 5'b00011,
    parameter logic [4:0] OP_DIV = 5'b00100,
    parameter logic [4:0] OP_OR  = 5'b00101
) (
    input  logic                   Clock,
    input  logic                   Clear,
    hardwired_control_seq_if.master ctrl
);

    typedef enum logic [3:0] {
        StIdle = 4'd0,
        StT0   = 4'd1,
        StT1   = 4'd2,
        StT2   = 4'd3,
        StT3   = 4'd4,
        StT4   = 4'd5,
        StT5   = 4'd6,
        StT6   = 4'd7,
        StHalt = 4'd8
    } state_e;

    state_e state_q, state_d;

    logic [4:0] opcode;
    logic       op_alu;
    logic       op_long;
    logic       op_legal;
    logic       unused_ir;

    assign opcode    = ctrl.IR[31:27];
    assign unused_ir = ^ctrl.IR[26:0];

    assign op_alu   = (opcode == OP_ADD) || (opcode == OP_SUB) ||
                      (opcode == OP_AND) || (opcode == OP_OR);
    assign op_long  = (opcode == OP_MUL) || (opcode == OP_DIV);
    assign op_legal = op_alu || op_long;

    always_ff @(posedge Clock or posedge Clear) begin
        if (Clear) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Run is only looked at in IDLE and in the final execute state.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: state_d = ctrl.Run ? StT0 : StIdle;
            StT0:   state_d = StT1;
            StT1:   state_d = StT2;
            StT2:   state_d = StT3;
            StT3:   state_d = op_legal ? StT4 : StHalt;
            StT4:   state_d = StT5;
            StT5: begin
                if (op_long) begin
                    state_d = StT6;
                end else begin
                    state_d = ctrl.Run ? StT0 : StIdle;
                end
            end
            StT6:   state_d = ctrl.Run ? StT0 : StIdle;
            StHalt: state_d = StHalt;
            default: state_d = StIdle;
        endcase
    end

    logic pc_out, zhi_out, zlow_out, mdr_out;
    logic mar_in, z_in, pc_in, mdr_in, ir_in, y_in, hi_in, lo_in;
    logic inc_pc, read;
    logic gra, grb, grc, r_in, r_out;
    logic alu_add, alu_sub, alu_and, alu_or, alu_mul, alu_div;
    logic done, illegal;

    always_comb begin
        pc_out   = 1'b0;
        zhi_out  = 1'b0;
        zlow_out = 1'b0;
        mdr_out  = 1'b0;
        mar_in   = 1'b0;
        z_in     = 1'b0;
        pc_in    = 1'b0;
        mdr_in   = 1'b0;
        ir_in    = 1'b0;
        y_in     = 1'b0;
        hi_in    = 1'b0;
        lo_in    = 1'b0;
        inc_pc   = 1'b0;
        read     = 1'b0;
        gra      = 1'b0;
        grb      = 1'b0;
        grc      = 1'b0;
        r_in     = 1'b0;
        r_out    = 1'b0;
        alu_add  = 1'b0;
        alu_sub  = 1'b0;
        alu_and  = 1'b0;
        alu_or   = 1'b0;
        alu_mul  = 1'b0;
        alu_div  = 1'b0;
        done     = 1'b0;
        illegal  = 1'b0;
        case (state_q)
            StT0: begin
                pc_out = 1'b1;
                mar_in = 1'b1;
                inc_pc = 1'b1;
                z_in   = 1'b1;
            end
            StT1: begin
                zlow_out = 1'b1;
                pc_in    = 1'b1;
                read     = 1'b1;
                mdr_in   = 1'b1;
            end
            StT2: begin
                mdr_out = 1'b1;
                ir_in   = 1'b1;
            end
            StT3: begin
                // An undecodable opcode leaves T3 silent on its way to HALT.
                if (op_legal) begin
                    grb   = 1'b1;
                    r_out = 1'b1;
                    y_in  = 1'b1;
                end
            end
            StT4: begin
                grc     = 1'b1;
                r_out   = 1'b1;
                z_in    = 1'b1;
                alu_add = (opcode == OP_ADD);
                alu_sub = (opcode == OP_SUB);
                alu_and = (opcode == OP_AND);
                alu_or  = (opcode == OP_OR);
                alu_mul = (opcode == OP_MUL);
                alu_div = (opcode == OP_DIV);
            end
            StT5: begin
                zlow_out = 1'b1;
                if (op_long) begin
                    lo_in = 1'b1;
                end else begin
                    gra  = 1'b1;
                    r_in = 1'b1;
                    done = 1'b1;
                end
            end
            StT6: begin
                zhi_out = 1'b1;
                hi_in   = 1'b1;
                done    = 1'b1;
            end
            StHalt: illegal = 1'b1;
            default: ;
        endcase
    end

    assign ctrl.PCout   = pc_out;
    assign ctrl.Zhiout  = zhi_out;
    assign ctrl.Zlowout = zlow_out;
    assign ctrl.MDRout  = mdr_out;
    // Reserved for MFHI/MFLO.
    assign ctrl.HIout   = 1'b0;
    assign ctrl.LOout   = 1'b0;

    assign ctrl.MARin = mar_in;
    assign ctrl.Zin   = z_in;
    assign ctrl.PCin  = pc_in;
    assign ctrl.MDRin = mdr_in;
    assign ctrl.IRin  = ir_in;
    assign ctrl.Yin   = y_in;
    assign ctrl.HIin  = hi_in;
    assign ctrl.LOin  = lo_in;

    assign ctrl.IncPC = inc_pc;
    assign ctrl.Read  = read;

    assign ctrl.Gra  = gra;
    assign ctrl.Grb  = grb;
    assign ctrl.Grc  = grc;
    assign ctrl.Rin  = r_in;
    assign ctrl.Rout = r_out;

    assign ctrl.ADD = alu_add;
    assign ctrl.SUB = alu_sub;
    assign ctrl.AND = alu_and;
    assign ctrl.OR  = alu_or;
    assign ctrl.MUL = alu_mul;
    assign ctrl.DIV = alu_div;

    assign ctrl.Done    = done;
    assign ctrl.Illegal = illegal;
    assign ctrl.state   = state_q;

endmodule

// File: tb/tb_hardwired_control_seq.sv
// Self-checking bench: randomized instruction streams checked against a table-driven
// per-instruction strobe schedule, plus directed clear/halt scenarios.
module tb_hardwired_control_seq;

    logic Clock;
    logic Clear;

    hardwired_control_seq_if bus ();

    hardwired_control_seq dut (
        .Clock (Clock),
        .Clear (Clear),
        .ctrl  (bus)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Observed strobes packed, bit 0 = PCout ... bit 28 = Illegal.
    logic [28:0] obs_v;
    assign obs_v = {bus.Illegal, bus.Done, bus.DIV, bus.MUL, bus.OR, bus.AND, bus.SUB, bus.ADD,
                    bus.Rout, bus.Rin, bus.Grc, bus.Grb, bus.Gra, bus.Read, bus.IncPC,
                    bus.LOin, bus.HIin, bus.Yin, bus.IRin, bus.MDRin, bus.PCin, bus.Zin,
                    bus.MARin, bus.LOout, bus.HIout, bus.MDRout, bus.Zlowout, bus.Zhiout,
                    bus.PCout};

    localparam logic [28:0] MPcout   = 29'd1 << 0;
    localparam logic [28:0] MZhiout  = 29'd1 << 1;
    localparam logic [28:0] MZlowout = 29'd1 << 2;
    localparam logic [28:0] MMdrout  = 29'd1 << 3;
    localparam logic [28:0] MMarin   = 29'd1 << 6;
    localparam logic [28:0] MZin     = 29'd1 << 7;
    localparam logic [28:0] MPcin    = 29'd1 << 8;
    localparam logic [28:0] MMdrin   = 29'd1 << 9;
    localparam logic [28:0] MIrin    = 29'd1 << 10;
    localparam logic [28:0] MYin     = 29'd1 << 11;
    localparam logic [28:0] MHiin    = 29'd1 << 12;
    localparam logic [28:0] MLoin    = 29'd1 << 13;
    localparam logic [28:0] MIncpc   = 29'd1 << 14;
    localparam logic [28:0] MRead    = 29'd1 << 15;
    localparam logic [28:0] MGra     = 29'd1 << 16;
    localparam logic [28:0] MGrb     = 29'd1 << 17;
    localparam logic [28:0] MGrc     = 29'd1 << 18;
    localparam logic [28:0] MRin     = 29'd1 << 19;
    localparam logic [28:0] MRout    = 29'd1 << 20;
    localparam logic [28:0] MAdd     = 29'd1 << 21;
    localparam logic [28:0] MSub     = 29'd1 << 22;
    localparam logic [28:0] MAnd     = 29'd1 << 23;
    localparam logic [28:0] MOr      = 29'd1 << 24;
    localparam logic [28:0] MMul     = 29'd1 << 25;
    localparam logic [28:0] MDiv     = 29'd1 << 26;
    localparam logic [28:0] MDone    = 29'd1 << 27;
    localparam logic [28:0] MIllegal = 29'd1 << 28;

    typedef struct packed {
        logic [3:0]  st;
        logic [28:0] v;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] prog_q[$];

    int n_cmp  = 0;
    int n_fail = 0;

    // Expected schedule of one instruction, straight from the opcode's behaviour.
    function automatic void push_instr(input logic [31:0] instr);
        logic [28:0] sel;
        bit          is_long;
        sel     = '0;
        is_long = 1'b0;
        case (instr[31:27])
            5'b00000: sel = MAdd;
            5'b00001: sel = MSub;
            5'b00010: sel = MAnd;
            5'b00101: sel = MOr;
            5'b00011: begin sel = MMul; is_long = 1'b1; end
            5'b00100: begin sel = MDiv; is_long = 1'b1; end
            default:  sel = '0;
        endcase
        exp_q.push_back('{st: 4'd1, v: MPcout | MMarin | MIncpc | MZin});
        exp_q.push_back('{st: 4'd2, v: MZlowout | MPcin | MRead | MMdrin});
        exp_q.push_back('{st: 4'd3, v: MMdrout | MIrin});
        if (sel == '0) begin
            exp_q.push_back('{st: 4'd4, v: '0});
            exp_q.push_back('{st: 4'd8, v: MIllegal});
            return;
        end
        exp_q.push_back('{st: 4'd4, v: MGrb | MRout | MYin});
        exp_q.push_back('{st: 4'd5, v: MGrc | MRout | MZin | sel});
        if (is_long) begin
            exp_q.push_back('{st: 4'd6, v: MZlowout | MLoin});
            exp_q.push_back('{st: 4'd7, v: MZhiout | MHiin | MDone});
        end else begin
            exp_q.push_back('{st: 4'd6, v: MZlowout | MGra | MRin | MDone});
        end
    endfunction

    // Plays prog_q from IDLE; go_pct is the chance Run is raised when a new pass may start.
    task automatic run_stream(input string tag, input int go_pct, input int max_cycles,
                              output int ncycles, output int ndone);
        exp_t        cur;
        int          halt_cnt;
        bit          decide;
        bit          r;
        logic [31:0] instr;
        cur      = '{st: 4'd0, v: '0};
        halt_cnt = 0;
        ncycles  = 0;
        ndone    = 0;
        exp_q.delete();
        forever begin
            if (cur.st == 4'd8 && halt_cnt >= 10) break;
            decide = (exp_q.size() == 0) && (cur.st == 4'd0 || cur.v[27]);
            if (decide && cur.st == 4'd0 && prog_q.size() == 0) break;
            if (ncycles >= max_cycles) begin
                n_cmp++;
                n_fail++;
                $display("FAIL %s budget: got %0d cycles, required completion", tag, ncycles);
                break;
            end
            if (decide) r = (prog_q.size() != 0) && ($urandom_range(0, 99) < go_pct);
            else        r = $urandom_range(0, 1) == 1;
            bus.Run = r;
            @(posedge Clock);
            #1;
            ncycles++;
            if (exp_q.size() != 0) begin
                cur = exp_q.pop_front();
            end else if (cur.st == 4'd8) begin
                halt_cnt++;
            end else if (r) begin
                instr  = prog_q.pop_front();
                bus.IR = instr;
                push_instr(instr);
                cur = exp_q.pop_front();
            end else begin
                cur = '{st: 4'd0, v: '0};
            end
            #1;
            if (cur.v[27]) ndone++;
            n_cmp++;
            if (bus.state !== cur.st) begin
                n_fail++;
                $display("FAIL %s state cyc %0d: got %0d required %0d",
                         tag, ncycles, bus.state, cur.st);
            end
            n_cmp++;
            if (obs_v !== cur.v) begin
                n_fail++;
                $display("FAIL %s strobes cyc %0d st %0d: got %h required %h",
                         tag, ncycles, cur.st, obs_v, cur.v);
            end
            n_cmp++;
            if ($countones(obs_v[26:21]) > 1) begin
                n_fail++;
                $display("FAIL %s alu_onehot cyc %0d: got %b required at most one",
                         tag, ncycles, obs_v[26:21]);
            end
            n_cmp++;
            if ($countones({obs_v[20], obs_v[5:0]}) > 1) begin
                n_fail++;
                $display("FAIL %s bus_drivers cyc %0d: got %b required at most one",
                         tag, ncycles, {obs_v[20], obs_v[5:0]});
            end
            n_cmp++;
            if ((obs_v[19] || obs_v[20]) && $countones(obs_v[18:16]) != 1) begin
                n_fail++;
                $display("FAIL %s gr_select cyc %0d: got Gr=%b required exactly one",
                         tag, ncycles, obs_v[18:16]);
            end
        end
    endtask

    task automatic step_idle_check(input string tag, input int n);
        for (int i = 0; i < n; i++) begin
            bus.Run = 1'b0;
            @(posedge Clock);
            #2;
            n_cmp++;
            if (bus.state !== 4'd0 || obs_v !== '0) begin
                n_fail++;
                $display("FAIL %s idle cyc %0d: got st %0d strobes %h required 0/0",
                         tag, i, bus.state, obs_v);
            end
        end
    endtask

    task automatic test_reset();
        Clear   = 1'b1;
        bus.Run = 1'b1;
        bus.IR  = $urandom;
        repeat (2) @(posedge Clock);
        #1;
        n_cmp++;
        if (bus.state !== 4'd0 || obs_v !== '0) begin
            n_fail++;
            $display("FAIL reset: got st %0d strobes %h required 0/0", bus.state, obs_v);
        end
        Clear   = 1'b0;
        bus.Run = 1'b0;
        step_idle_check("reset_idle", 2);
    endtask

    task automatic test_clear_mid_t4();
        bus.IR  = 32'h00920000;
        bus.Run = 1'b1;
        @(posedge Clock);
        #1;
        bus.Run = 1'b0;
        repeat (4) @(posedge Clock);
        #1;
        n_cmp++;
        if (bus.state !== 4'd5) begin
            n_fail++;
            $display("FAIL clear_pre_t4: got st %0d required 5", bus.state);
        end
        #2 Clear = 1'b1;
        #1;
        n_cmp++;
        if (bus.state !== 4'd0 || obs_v !== '0) begin
            n_fail++;
            $display("FAIL clear_async: got st %0d strobes %h required 0/0", bus.state, obs_v);
        end
        #1 Clear = 1'b0;
        step_idle_check("clear_after", 3);
    endtask

    task automatic test_mul();
        int nc, nd;
        prog_q = '{32'h1A920000};
        run_stream("mul", 100, 50, nc, nd);
        n_cmp++;
        if (nc !== 8 || nd !== 1) begin
            n_fail++;
            $display("FAIL mul_len: got %0d cycles %0d done required 8/1", nc, nd);
        end
    endtask

    task automatic test_back_to_back();
        int nc, nd;
        prog_q = '{32'h20920000, 32'h20920000, 32'h20920000};
        run_stream("div_b2b", 100, 100, nc, nd);
        n_cmp++;
        if (nc !== 22 || nd !== 3) begin
            n_fail++;
            $display("FAIL div_b2b_len: got %0d cycles %0d done required 22/3", nc, nd);
        end
    endtask

    task automatic test_add();
        int nc, nd;
        prog_q = '{32'h00920000, 32'h00920000};
        run_stream("add", 100, 50, nc, nd);
        n_cmp++;
        if (nc !== 13 || nd !== 2) begin
            n_fail++;
            $display("FAIL add_len: got %0d cycles %0d done required 13/2", nc, nd);
        end
    endtask

    task automatic test_random();
        int          nc, nd;
        logic [4:0]  ops[6];
        logic [31:0] w;
        ops = '{5'b00000, 5'b00001, 5'b00010, 5'b00011, 5'b00100, 5'b00101};
        prog_q.delete();
        for (int i = 0; i < 40; i++) begin
            w = $urandom;
            prog_q.push_back({ops[$urandom_range(0, 5)], w[26:0]});
        end
        run_stream("random", 70, 2000, nc, nd);
        n_cmp++;
        if (nd !== 40) begin
            n_fail++;
            $display("FAIL random_done: got %0d required 40", nd);
        end
    endtask

    task automatic test_illegal();
        int nc, nd;
        prog_q = '{32'hF8000000};
        run_stream("illegal", 100, 50, nc, nd);
        n_cmp++;
        if (bus.state !== 4'd8 || obs_v !== MIllegal) begin
            n_fail++;
            $display("FAIL halt_hold: got st %0d strobes %h required 8/%h",
                     bus.state, obs_v, MIllegal);
        end
        #2 Clear = 1'b1;
        #1;
        n_cmp++;
        if (bus.state !== 4'd0 || obs_v !== '0) begin
            n_fail++;
            $display("FAIL halt_clear: got st %0d strobes %h required 0/0", bus.state, obs_v);
        end
        #1 Clear = 1'b0;
        step_idle_check("halt_after", 2);
    endtask

    initial begin
        Clear   = 1'b1;
        bus.Run = 1'b0;
        bus.IR  = '0;
        test_reset();
        test_clear_mid_t4();
        test_mul();
        test_back_to_back();
        test_add();
        test_random();
        test_illegal();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/hardwired_control_seq.md
Name: hardwired_control_seq

Overview:
- Hardwired control sequencer that generates the datapath control strobes for one instruction per pass: fetch (T0–T2), then a decode-driven execute sequence.
- Covers 3-register ALU ops (ADD, SUB, AND, OR) and the 64-bit-result ops (MUL, DIV), which write Z low into LO and Z high into HI.
- Sits beside the Datapath. It drives every control input the Datapath exposes and reads back the IR contents.

Parameters:
- OP_ADD, 5'b00000, opcode for ADD
- OP_SUB, 5'b00001, opcode for SUB
- OP_AND, 5'b00010, opcode for AND
- OP_MUL, 5'b00011, opcode for MUL
- OP_DIV, 5'b00100, opcode for DIV
- OP_OR, 5'b00101, opcode for OR

Ports:
- Clock  in  1  system clock; all state changes on the rising edge
- Clear  in  1  reset, asynchronous, active-high
- Run  in  1  start/continue request
- IR  in  32  instruction register contents from the Datapath; opcode is IR[31:27]
- PCout, Zhiout, Zlowout, MDRout, HIout, LOout  out  1 each  bus drive enables
- MARin, Zin, PCin, MDRin, IRin, Yin, HIin, LOin  out  1 each  register load enables
- IncPC, Read  out  1 each  PC increment through the ALU; memory read into MDR
- Gra, Grb, Grc  out  1 each  register-field select for the Ra, Rb or Rc field
- Rin, Rout  out  1 each  general-register load / drive, qualified by the Gr* selects
- ADD, SUB, AND, OR, MUL, DIV  out  1 each  one-hot ALU operation select
- Done  out  1  high during the final execute state of an instruction
- Illegal  out  1  high while in HALT
- state  out  4  current state encoding, for debug

Behaviour:
- State encoding: IDLE=0, T0=1, T1=2, T2=3, T3=4, T4=5, T5=6, T6=7, HALT=8.
- Clear high: state goes to IDLE immediately, with no wait for a clock edge. This applies in any state, including mid-instruction.
- Outputs in IDLE: every output is 0 and state=0.
- Output timing: all outputs are decoded combinationally from the state register and IR only; no output depends on Run. Each state lasts exactly one clock cycle.
- IDLE: Run=1 at a rising edge moves to T0; otherwise the sequencer stays in IDLE. T0 is active in the cycle after the edge that sampled Run.
- T0: PCout, MARin, IncPC, Zin.
- T1: Zlowout, PCin, Read, MDRin.
- T2: MDRout, IRin. IR is valid from T3 onward, because the Datapath loads it at the end of T2.
- T3: Grb, Rout, Yin. Opcode decode happens here. An opcode matching none of the six OP_* parameters drives all outputs 0 in T3, and the next state is HALT.
- T4: Grc, Rout, Zin, plus exactly one ALU select matching the opcode.
- T5, ALU ops: Zlowout, Gra, Rin, Done. This is the last state.
- T5, MUL/DIV: Zlowout, LOin.
- T6 (MUL/DIV only): Zhiout, HIin, Done. This is the last state.
- After the last state: Run=1 at the edge goes to T0 with no idle bubble; Run=0 goes to IDLE.
- Run is ignored in every state except IDLE and the last state. Dropping Run mid-instruction does not abort.
- HALT: Illegal=1, all other outputs 0. The only exit is Clear.
- HIout and LOout are always 0. They are reserved for MFHI/MFLO.
- ALU selects: at most one is ever high, and only in T4.
- Bus drivers: at most one of PCout, Zhiout, Zlowout, MDRout, HIout, LOout, Rout is high in any state.
- Per-instruction cycle count from T0: ALU op = 6 cycles, MUL/DIV = 7 cycles.

Test Plan:
- Clear pulse in mid-T4 (async, between edges) -> state=0 and all outputs 0 before the next rising edge; Run=0 afterwards -> stays in IDLE.
- Run=1 one cycle, IR=32'h1A920000 (MUL, Ra=5, Rb=2, Rc=4) -> states T0..T6 in 7 consecutive cycles.
  - T3: Grb, Rout, Yin.
  - T4: Grc, Rout, MUL, Zin.
  - T5: Zlowout, LOin.
  - T6: Zhiout, HIin, Done.
  - Then IDLE.
- IR=32'h20920000 (DIV) with Run held high -> T6 is followed directly by T0.
  - DIV high in T4 only.
  - Done high exactly 1 cycle per 7.
- IR=32'h00920000 (ADD) -> T5 asserts Zlowout, Gra, Rin, Done; T6 never entered; ADD high in T4 only.
- IR=32'hF8000000 (opcode 11111) -> T3 outputs all 0, then HALT with Illegal=1.
  - Stays in HALT for 10 cycles with Run toggling.
  - A Clear pulse returns to IDLE.
- Every cycle of all scenarios -> assertions hold:
  - one-hot (or zero) ALU select;
  - at most one bus driver high;
  - Rin or Rout only with exactly one of Gra, Grb, Grc.
